// File: rtl/cpu_defs.sv
// Shared CPU definitions: load type codes, writeback FSM states, register constants.
package cpu_defs;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 5;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LW  = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: selects byte/half/word by byte offset and sign/zero-extends.
module load_extend
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrlo,
  input  logic [2:0]  loadtype,
  output logic [31:0] ext_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the load type; unknown codes act as LW.
  always_comb begin
    byte_sel = rdata[{addrlo, 3'b000} +: 8];
    half_sel = addrlo[1] ? rdata[31:16] : rdata[15:0];
    ext_c    = rdata;
    case (loadtype)
      LT_LB:   ext_c = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  ext_c = {24'd0, byte_sel};
      LT_LH:   ext_c = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  ext_c = {16'd0, half_sel};
      LT_LW:   ext_c = rdata;
      default: ext_c = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: W pipeline register, load-response wait FSM, register-file write port.
// Optional macro WB_TRACE_EN adds the debug_wb_* retirement trace ports and the pcW register.
module wb_stage
  import cpu_defs::*;
#(
  parameter int unsigned DW = WB_DW,
  parameter int unsigned AW = WB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallW,
  input  logic          flushW,
  input  logic          validM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic [2:0]    loadtypeM,
  input  logic [1:0]    addrloM,
  input  logic [AW-1:0] writeregM,
  input  logic [DW-1:0] aluoutM,
  input  logic [31:0]   pcM,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          regwriteW,
  output logic          stall_reqW
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [4:0]    debug_wb_rf_wnum,
  output logic [31:0]   debug_wb_rf_wdata
`endif
);

  logic          validW;
  logic          regwrite_r;
  logic          memtoregW;
  logic [2:0]    loadtypeW;
  logic [1:0]    addrloW;
  logic [AW-1:0] writeregW;
  logic [DW-1:0] aluoutW;
  logic [DW-1:0] load_buf;

  wb_state_e     state;
  wb_state_e     state_nxt;

  logic          rsp_now;
  logic          ready;
  logic [31:0]   load_raw;
  logic [31:0]   load_val;

  // W pipeline register: advance from M, squash on flush, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      validW     <= 1'b0;
      regwrite_r <= 1'b0;
      memtoregW  <= 1'b0;
      loadtypeW  <= 3'd0;
      addrloW    <= 2'd0;
      writeregW  <= '0;
      aluoutW    <= '0;
    end else if (!stallW) begin
      if (flushW) begin
        validW <= 1'b0;
      end else begin
        validW     <= validM;
        regwrite_r <= regwriteM;
        memtoregW  <= memtoregM;
        loadtypeW  <= loadtypeM;
        addrloW    <= addrloM;
        writeregW  <= writeregM;
        aluoutW    <= aluoutM;
      end
    end
  end

  // Load response buffer, filled only while a load is waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_buf <= '0;
    end else if (rsp_now) begin
      load_buf <= mem_rdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a W advance restarts tracking; otherwise only WAIT reacts to the response.
  always_comb begin
    state_nxt = state;
    if (!stallW) begin
      if (!flushW && validM && memtoregM) begin
        state_nxt = WB_WAIT;
      end else begin
        state_nxt = WB_IDLE;
      end
    end else if (rsp_now) begin
      state_nxt = WB_DONE;
    end
  end

  // Write-port outputs: data readiness, alignment source and $0 suppression.
  always_comb begin
    rsp_now    = (state == WB_WAIT) && mem_rvalid;
    stall_reqW = (state == WB_WAIT) && !mem_rvalid;
    ready      = !memtoregW || (state == WB_DONE) || rsp_now;
    load_raw   = (state == WB_DONE) ? 32'(load_buf) : 32'(mem_rdata);
    wa3        = writeregW;
    wd3        = memtoregW ? DW'(load_val) : aluoutW;
    regwriteW  = validW && regwrite_r;
    we3        = validW && regwrite_r && ready && (writeregW != AW'(REG_ZERO));
  end

  load_extend u_load_extend (
    .rdata    (load_raw),
    .addrlo   (addrloW),
    .loadtype (loadtypeW),
    .ext_c    (load_val)
  );

`ifdef WB_TRACE_EN
  logic [31:0] pcW;

  // Retired-instruction PC, tracked alongside the W register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcW <= 32'd0;
    end else if (!stallW && !flushW) begin
      pcW <= pcM;
    end
  end

  // Trace mirrors the write port; enable pulses only in the cycle the regfile accepts the write.
  always_comb begin
    debug_wb_pc       = pcW;
    debug_wb_rf_wen   = {4{we3 && !stallW}};
    debug_wb_rf_wnum  = 5'(wa3);
    debug_wb_rf_wdata = 32'(wd3);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pcM;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: alignment vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        stallW, flushW, validM, regwriteM, memtoregM;
  logic [2:0]  loadtypeM;
  logic [1:0]  addrloM;
  logic [4:0]  writeregM;
  logic [31:0] aluoutM, pcM, mem_rdata;
  logic        mem_rvalid;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        regwriteW, stall_reqW;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int total = 0;
  int bad   = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
    .validM(validM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .loadtypeM(loadtypeM), .addrloM(addrloM), .writeregM(writeregM),
    .aluoutM(aluoutM), .pcM(pcM), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .we3(we3), .wa3(wa3), .wd3(wd3), .regwriteW(regwriteW), .stall_reqW(stall_reqW)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic rw, input logic ld, input logic [2:0] lt,
                         input logic [1:0] lo, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc);
    validM = v; regwriteM = rw; memtoregM = ld; loadtypeM = lt;
    addrloM = lo; writeregM = rd; aluoutM = alu; pcM = pc;
  endtask

  // Reference load extension written from the rules with shifts and arithmetic.
  function automatic logic [31:0] ref_ext(input logic [2:0] lt, input logic [1:0] lo,
                                          input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (lt)
      3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      3'd1:    return 32'(b);
      3'd2:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      3'd3:    return 32'(h);
      default: return w;
    endcase
  endfunction

  typedef struct {
    logic        load;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        load;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
  } winst_t;

  vec_t vecs[13];

  initial begin
    winst_t mw, mi;
    logic   held, pending, ready, e_we, e_stall;
    logic [31:0] word, e_wd;
`ifdef WB_TRACE_EN
    int pulses;
`endif

    vecs[0]  = '{1'b0, 3'd0, 2'd0, 5'd5,  32'h0000_1234, 32'h0,         1'b1, 32'h0000_1234};
    vecs[1]  = '{1'b0, 3'd0, 2'd0, 5'd0,  32'h0000_DEAD, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b1, 3'd0, 2'd3, 5'd7,  32'h0,         32'h80FF_FFFF, 1'b1, 32'hFFFF_FF80};
    vecs[3]  = '{1'b1, 3'd1, 2'd3, 5'd7,  32'h0,         32'h80FF_FFFF, 1'b1, 32'h0000_0080};
    vecs[4]  = '{1'b1, 3'd0, 2'd0, 5'd8,  32'h0,         32'h1234_567F, 1'b1, 32'h0000_007F};
    vecs[5]  = '{1'b1, 3'd0, 2'd1, 5'd9,  32'h0,         32'h0000_A500, 1'b1, 32'hFFFF_FFA5};
    vecs[6]  = '{1'b1, 3'd3, 2'd2, 5'd10, 32'h0,         32'hBEEF_0000, 1'b1, 32'h0000_BEEF};
    vecs[7]  = '{1'b1, 3'd2, 2'd2, 5'd11, 32'h0,         32'hBEEF_0000, 1'b1, 32'hFFFF_BEEF};
    vecs[8]  = '{1'b1, 3'd2, 2'd1, 5'd12, 32'h0,         32'h1234_8001, 1'b1, 32'hFFFF_8001};
    vecs[9]  = '{1'b1, 3'd3, 2'd3, 5'd13, 32'h0,         32'h7FFF_0000, 1'b1, 32'h0000_7FFF};
    vecs[10] = '{1'b1, 3'd4, 2'd2, 5'd14, 32'h0,         32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 3'd7, 2'd1, 5'd15, 32'h0,         32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF};
    vecs[12] = '{1'b1, 3'd4, 2'd0, 5'd0,  32'h0,         32'h1111_2222, 1'b0, 32'h0};

    rst = 1'b0; stallW = 1'b0; flushW = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    drive_m(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_wa3", 32'(wa3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_regwriteW", 32'(regwriteW), 32'd0);
    chk("rst_stall_reqW", 32'(stall_reqW), 32'd0);
    rst = 1'b1;
    tick();

    // Table: each instruction retires in its first W cycle (load data arrives with it).
    foreach (vecs[i]) begin
      drive_m(1'b1, 1'b1, vecs[i].load, vecs[i].lt, vecs[i].lo, vecs[i].rd, vecs[i].alu, 32'h0);
      tick();
      validM = 1'b0;
      mem_rvalid = vecs[i].load;
      mem_rdata  = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_we3", i), 32'(we3), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_stall", i), 32'(stall_reqW), 32'd0);
      chk($sformatf("vec%0d_wa3", i), 32'(wa3), 32'(vecs[i].rd));
      if (vecs[i].exp_we) chk($sformatf("vec%0d_wd3", i), wd3, vecs[i].exp_wd);
      tick();
      mem_rvalid = 1'b0;
    end

    // LB with the response two cycles after W entry; data then held in the buffer under stall.
    drive_m(1'b1, 1'b1, 1'b1, 3'd0, 2'd3, 5'd7, 32'h0, 32'h0);
    tick();
    validM = 1'b0; stallW = 1'b1; #1;
    chk("lb_wait1_stall", 32'(stall_reqW), 32'd1);
    chk("lb_wait1_we3", 32'(we3), 32'd0);
    tick(); #1;
    chk("lb_wait2_stall", 32'(stall_reqW), 32'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FFFF; #1;
    chk("lb_rsp_stall", 32'(stall_reqW), 32'd0);
    chk("lb_rsp_we3", 32'(we3), 32'd1);
    chk("lb_rsp_wd3", wd3, 32'hFFFF_FF80);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
    chk("lb_done_we3", 32'(we3), 32'd1);
    chk("lb_done_wd3", wd3, 32'hFFFF_FF80);
    chk("lb_done_stall", 32'(stall_reqW), 32'd0);
    stallW = 1'b0;
    tick(); #1;
    chk("lb_after_we3", 32'(we3), 32'd0);

    // Flush squashes a valid write; flush during stall is ignored.
    drive_m(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h99, 32'h0);
    flushW = 1'b1;
    tick(); #1;
    chk("flush_we3", 32'(we3), 32'd0);
    chk("flush_regwriteW", 32'(regwriteW), 32'd0);
    flushW = 1'b0;
    drive_m(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd10, 32'h55, 32'h0);
    tick();
    validM = 1'b0; stallW = 1'b1; flushW = 1'b1;
    tick(); #1;
    chk("stallflush_we3", 32'(we3), 32'd1);
    chk("stallflush_wa3", 32'(wa3), 32'd10);
    stallW = 1'b0; flushW = 1'b0;
    tick();

    // Reset while waiting; a late response must be ignored.
    drive_m(1'b1, 1'b1, 1'b1, 3'd4, 2'd0, 5'd3, 32'h0, 32'h0);
    tick();
    validM = 1'b0; stallW = 1'b1; #1;
    chk("rstwait_stall_pre", 32'(stall_reqW), 32'd1);
    rst = 1'b0;
    tick(); #1;
    chk("rstwait_stall", 32'(stall_reqW), 32'd0);
    chk("rstwait_wa3", 32'(wa3), 32'd0);
    chk("rstwait_wd3", wd3, 32'd0);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; #1;
    chk("rstwait_late_we3", 32'(we3), 32'd0);
    chk("rstwait_late_stall", 32'(stall_reqW), 32'd0);
    tick();
    mem_rvalid = 1'b0; stallW = 1'b0; #1;
    chk("rstwait_after_we3", 32'(we3), 32'd0);
    chk("rstwait_after_regwriteW", 32'(regwriteW), 32'd0);

`ifdef WB_TRACE_EN
    // Trace enable pulses once for a write held three cycles by stall.
    drive_m(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd12, 32'hABCD, 32'h0040_0100);
    tick();
    validM = 1'b0; stallW = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) stallW = 1'b0;
      #1;
      if (debug_wb_rf_wen == 4'hF) pulses++;
      chk("trace_pc", debug_wb_pc, 32'h0040_0100);
      chk("trace_we3", 32'(we3), 32'd1);
      chk("trace_wen", 32'(debug_wb_rf_wen), (c == 3) ? 32'hF : 32'h0);
      tick();
    end
    #1;
    if (debug_wb_rf_wen != 4'h0) pulses++;
    chk("trace_pulses", 32'(pulses), 32'd1);
`endif

    // Randomized traffic against a transaction model.
    rst = 1'b0; stallW = 1'b0; flushW = 1'b0; mem_rvalid = 1'b0;
    drive_m(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    mw = '0; held = 1'b0; word = 32'h0;
    for (int n = 0; n < 600; n++) begin
      mi.valid = ($urandom % 4) != 0;
      mi.rw    = ($urandom % 4) != 0;
      mi.load  = 1'($urandom % 2);
      mi.lt    = 3'($urandom % 8);
      mi.lo    = 2'($urandom % 4);
      mi.rd    = 5'($urandom % 8);
      mi.alu   = $urandom;
      mi.pc    = $urandom;
      drive_m(mi.valid, mi.rw, mi.load, mi.lt, mi.lo, mi.rd, mi.alu, mi.pc);
      pending    = mw.valid && mw.load && !held;
      mem_rvalid = pending ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      mem_rdata  = $urandom;
      e_stall    = pending && !mem_rvalid;
      stallW     = e_stall || (($urandom % 4) == 0);
      flushW     = ($urandom % 8) == 0;
      ready      = !mw.load || held || (pending && mem_rvalid);
      e_we       = mw.valid && mw.rw && ready && (mw.rd != 5'd0);
      e_wd       = mw.load ? ref_ext(mw.lt, mw.lo, held ? word : mem_rdata) : mw.alu;
      #1;
      chk("rnd_we3", 32'(we3), 32'(e_we));
      chk("rnd_stall", 32'(stall_reqW), 32'(e_stall));
      chk("rnd_regwriteW", 32'(regwriteW), 32'(mw.valid && mw.rw));
      if (mw.valid) chk("rnd_wa3", 32'(wa3), 32'(mw.rd));
      if (e_we) chk("rnd_wd3", wd3, e_wd);
`ifdef WB_TRACE_EN
      chk("rnd_trace_wen", 32'(debug_wb_rf_wen), (e_we && !stallW) ? 32'hF : 32'h0);
      if (mw.valid) chk("rnd_trace_pc", debug_wb_pc, mw.pc);
`endif
      @(posedge clk);
      if (!stallW) begin
        if (flushW) mw.valid = 1'b0;
        else        mw = mi;
        held = 1'b0;
      end else if (pending && mem_rvalid) begin
        held = 1'b1;
        word = mem_rdata;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
